// File: rtl/tdc_tap_decoder.sv
// Tapped-delay-line TDC front end: synchronises the raw tap levels, detects rising hits,
// and emits the coarse timestamp plus a bubble-tolerant fine code through a one-deep holding register.
module tdc_tap_decoder #(
  parameter int NTAPS = 32,
  parameter int CW    = 16,
  parameter int FW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NTAPS-1:0] taps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_coarse,
  output logic [FW-1:0]    out_fine,
  output logic [7:0]       lost_cnt
);

  typedef enum logic {
    WAIT_CLEAR = 1'b0,
    ARMED      = 1'b1
  } state_t;

  logic [NTAPS-1:0] r_s1;
  logic [NTAPS-1:0] r_s2;
  logic             r_s1_vld;
  logic             r_s2_vld;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_cnt_d1;
  logic [CW-1:0]    r_cnt_d2;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_s2_zero;
  logic             w_hit;
  logic             w_load;
  logic             w_drop;
  logic [FW-1:0]    w_pop;
  logic             r_valid;
  logic [CW-1:0]    r_coarse;
  logic [FW-1:0]    r_fine;
  logic [7:0]       r_lost;

  // Two-flop synchroniser; the _vld bits mark that s2 holds a real sample rather than reset zeros,
  // so taps already high at reset release can never be mistaken for a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1     <= taps;
      r_s2     <= r_s1;
      r_s1_vld <= 1'b1;
      r_s2_vld <= r_s1_vld;
    end
  end

  // Free-running coarse counter, delayed twice so r_cnt_d2 lines up with r_s2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_cnt_d1 <= '0;
      r_cnt_d2 <= '0;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
      r_cnt_d1 <= r_cnt;
      r_cnt_d2 <= r_cnt_d1;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NTAPS; i++) begin
      w_pop = w_pop + FW'(r_s2[i]);
    end
  end

  assign w_s2_zero = (r_s2 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = WAIT_CLEAR;
    end else begin
      case (r_state)
        WAIT_CLEAR: if (w_s2_zero && r_s2_vld) w_state_next = ARMED;
        ARMED:      if (!w_s2_zero)            w_state_next = WAIT_CLEAR;
        default:    w_state_next = WAIT_CLEAR;
      endcase
    end
  end

  always_comb begin
    w_hit = 1'b0;
    if (r_state == ARMED && en && !w_s2_zero) begin
      w_hit = 1'b1;
    end
  end

  // Single holding register: a hit loads it only when it is empty or being drained this cycle.
  assign w_load = w_hit && (!r_valid || out_ready);
  assign w_drop = w_hit && r_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_coarse <= '0;
      r_fine   <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_coarse <= r_cnt_d2;
      r_fine   <= w_pop;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lost <= '0;
    end else if (w_drop && r_lost != 8'hFF) begin
      r_lost <= r_lost + 8'd1;
    end
  end

  assign out_valid  = r_valid;
  assign out_coarse = r_coarse;
  assign out_fine   = r_fine;
  assign lost_cnt   = r_lost;

endmodule

// File: tb/tb_tdc_tap_decoder.sv
// Directed bench for tdc_tap_decoder (NTAPS=32, CW=16, FW=6): hit timing, popcount,
// backpressure drops, enable gating and asynchronous reset behaviour.
module tb_tdc_tap_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] taps;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_coarse;
  logic [5:0]  out_fine;
  logic [7:0]  lost_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] tb_cnt;
  logic [15:0] exp_coarse;
  int          nvalid;
  logic [5:0]  seen_fine;

  tdc_tap_decoder #(.NTAPS(32), .CW(16), .FW(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .taps       (taps),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_coarse (out_coarse),
    .out_fine   (out_fine),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  // Expected coarse counter value in the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 16'd0;
    else        tb_cnt <= tb_cnt + 16'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
    $display("[TB] %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; taps = 32'h0;
    steps(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_lost",  32'(lost_cnt),  32'd0);
    check("rst_fine",  32'(out_fine),  32'd0);
    rst_n = 1'b1;

    // Hit sampled while the counter reads 0x0100.
    for (int k = 0; k < 400 && tb_cnt != 16'h0100; k++) step();
    check("cnt_reach_0100", 32'(tb_cnt), 32'h0100);
    taps = 32'h0000_001F; step();
    taps = 32'hFFFF_FFFF; step();
    check("lat_not_early", 32'(out_valid), 32'd0);
    step();
    check("lat_valid",  32'(out_valid),  32'd1);
    check("lat_coarse", 32'(out_coarse), 32'h0100);
    check("lat_fine",   32'(out_fine),   32'd5);
    step();
    check("consumed", 32'(out_valid), 32'd0);

    // All taps high gives NTAPS.
    taps = 32'h0; steps(3);
    taps = 32'hFFFF_FFFF; steps(3);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_fine",  32'(out_fine),  32'd32);

    // Bubble pattern held for 10 cycles yields exactly one result.
    taps = 32'h0; steps(3);
    nvalid = 0; seen_fine = '0;
    taps = 32'h0000_005F;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) begin nvalid++; seen_fine = out_fine; end
    end
    taps = 32'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (out_valid) begin nvalid++; seen_fine = out_fine; end
    end
    check("bubble_count", 32'(nvalid), 32'd1);
    check("bubble_fine",  32'(seen_fine), 32'd6);

    // Drain and reload in the same cycle.
    out_ready = 1'b0;
    taps = 32'h0; steps(3);
    taps = 32'h1; step(); taps = 32'h0; steps(2);
    check("hold_a_valid", 32'(out_valid), 32'd1);
    check("hold_a_fine",  32'(out_fine),  32'd1);
    steps(2);
    check("hold_a_stable", 32'(out_fine), 32'd1);
    exp_coarse = tb_cnt;
    taps = 32'h3; step(); taps = 32'h0; step();
    out_ready = 1'b1; step();
    check("reload_valid",  32'(out_valid),  32'd1);
    check("reload_fine",   32'(out_fine),   32'd2);
    check("reload_coarse", 32'(out_coarse), 32'(exp_coarse));
    check("reload_lost",   32'(lost_cnt),   32'd0);
    step();
    check("reload_drain", 32'(out_valid), 32'd0);

    // Enable gating.
    taps = 32'h0; steps(3);
    en = 1'b0; taps = 32'h0000_00FF; nvalid = 0;
    for (int k = 0; k < 6; k++) begin step(); if (out_valid) nvalid++; end
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin step(); if (out_valid) nvalid++; end
    check("en_gate_none", 32'(nvalid), 32'd0);
    taps = 32'h0; steps(3);
    taps = 32'h0000_000F; steps(3);
    check("en_rearm_valid", 32'(out_valid), 32'd1);
    check("en_rearm_fine",  32'(out_fine),  32'd4);
    step();

    // Backpressure drops and saturation.
    out_ready = 1'b0;
    taps = 32'h0; steps(3);
    exp_coarse = tb_cnt;
    taps = 32'h3; step(); taps = 32'h0; steps(2);
    check("bp_first_valid", 32'(out_valid), 32'd1);
    steps(3);
    taps = 32'h7; step(); taps = 32'h0; steps(2);
    check("bp_lost1",        32'(lost_cnt),   32'd1);
    check("bp_held_fine",    32'(out_fine),   32'd2);
    check("bp_held_coarse",  32'(out_coarse), 32'(exp_coarse));
    step();
    for (int k = 0; k < 300; k++) begin
      taps = 32'h1; step(); taps = 32'h0; steps(2);
    end
    check("bp_lost_sat",   32'(lost_cnt),  32'd255);
    check("bp_still_valid", 32'(out_valid), 32'd1);
    check("bp_still_fine",  32'(out_fine),  32'd2);

    // Asynchronous reset mid-hold, taps high across release.
    #2;
    rst_n = 1'b0; taps = 32'hFFFF_FFFF;
    #1;
    check("arst_valid",  32'(out_valid),  32'd0);
    check("arst_lost",   32'(lost_cnt),   32'd0);
    check("arst_coarse", 32'(out_coarse), 32'd0);
    steps(2);
    rst_n = 1'b1; out_ready = 1'b1; nvalid = 0;
    for (int k = 0; k < 10; k++) begin step(); if (out_valid) nvalid++; end
    check("arst_no_result", 32'(nvalid), 32'd0);
    taps = 32'h0; steps(3);
    exp_coarse = tb_cnt;
    taps = 32'h1; step(); taps = 32'h0; steps(2);
    check("arst_new_valid",  32'(out_valid),  32'd1);
    check("arst_new_coarse", 32'(out_coarse), 32'(exp_coarse));
    check("arst_new_fine",   32'(out_fine),   32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
